// File: rtl/dmem_arbiter.sv
// Single-port data-memory controller for the MEM stage and an external requester.
// The CPU has priority, and a starvation counter forces the external requester to win.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  input  logic [1:0]  cpu_memwrite_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_stall_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        ext_req_i,
  input  logic [1:0]  ext_memwrite_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_wdata_i,
  output logic        ext_gnt_o,
  output logic        ext_rvalid_o,
  output logic [31:0] ext_rdata_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_be_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        align_err_o
);

  typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_e;

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic        ext_win, cpu_win;
  logic [1:0]  sel_mw;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misalign;

  assign ext_win = ext_req_i && (!cpu_req_i || starve_cnt_q == STARVE_MAX_C);
  assign cpu_win = cpu_req_i && !ext_win;

  assign sel_mw    = ext_win ? ext_memwrite_i : cpu_memwrite_i;
  assign sel_addr  = ext_win ? ext_addr_i     : cpu_addr_i;
  assign sel_wdata = ext_win ? ext_wdata_i    : cpu_wdata_i;

  // Little-endian lane steering; reads are full-word and must be word aligned.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    lane_be    = 4'b0000;
    lane_wdata = 32'h0;
    misalign   = 1'b0;
    unique case (sel_mw)
      2'b00: misalign = (sel_addr[1:0] != 2'b00);
      2'b01: begin
        misalign   = (sel_addr[1:0] != 2'b00);
        lane_be    = 4'b1111;
        lane_wdata = sel_wdata;
      end
      2'b10: begin
        misalign   = sel_addr[0];
        lane_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{sel_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b0001 << sel_addr[1:0];
        lane_wdata = {4{sel_wdata[7:0]}};
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    cpu_stall_o  = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = 32'h0;
    ext_gnt_o    = 1'b0;
    ext_rvalid_o = 1'b0;
    ext_rdata_o  = 32'h0;
    mem_en_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 30'h0;
    mem_wdata_o  = 32'h0;
    align_err_o  = 1'b0;
    // Outputs stay at their reset values while reset is held.
    if (!reset_i) begin
      unique case (state_q)
        IDLE: begin
          if (ext_win || !ext_req_i) begin
            starve_cnt_d = 4'd0;
          end else if (cpu_win && starve_cnt_q != STARVE_MAX_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          if (ext_win || cpu_win) begin
            ext_gnt_o   = ext_win;
            cpu_stall_o = ext_win && cpu_req_i;
            mem_addr_o  = sel_addr[31:2];
            if (misalign) begin
              align_err_o = 1'b1;
            end else begin
              mem_en_o    = 1'b1;
              mem_be_o    = lane_be;
              mem_wdata_o = lane_wdata;
              if (sel_mw == 2'b00) begin
                state_d = ext_win ? EXT_RD : CPU_RD;
                if (cpu_win) cpu_stall_o = 1'b1;
              end
            end
          end
        end
        CPU_RD: begin
          cpu_rvalid_o = 1'b1;
          cpu_rdata_o  = mem_rdata_i;
          state_d      = IDLE;
        end
        EXT_RD: begin
          ext_rvalid_o = 1'b1;
          ext_rdata_o  = mem_rdata_i;
          cpu_stall_o  = cpu_req_i;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs are driven 1 time unit after posedge and
// outputs are sampled on the following negedge.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cpu_req_i;
  logic [1:0]  cpu_memwrite_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic        cpu_stall_o, cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        ext_req_i;
  logic [1:0]  ext_memwrite_i;
  logic [31:0] ext_addr_i, ext_wdata_i;
  logic        ext_gnt_o, ext_rvalid_o;
  logic [31:0] ext_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_be_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        align_err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_req_i(cpu_req_i), .cpu_memwrite_i(cpu_memwrite_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_rdata_o(cpu_rdata_o),
    .ext_req_i(ext_req_i), .ext_memwrite_i(ext_memwrite_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o),
    .ext_rdata_o(ext_rdata_o),
    .mem_en_o(mem_en_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .align_err_o(align_err_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic drive_cpu(input logic req, input logic [1:0] mw,
                           input logic [31:0] addr, input logic [31:0] data);
    cpu_req_i = req; cpu_memwrite_i = mw; cpu_addr_i = addr; cpu_wdata_i = data;
  endtask

  task automatic drive_ext(input logic req, input logic [1:0] mw,
                           input logic [31:0] addr, input logic [31:0] data);
    ext_req_i = req; ext_memwrite_i = mw; ext_addr_i = addr; ext_wdata_i = data;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive_cpu(1'b1, 2'b00, 32'h40, 32'h0);
    drive_ext(1'b1, 2'b00, 32'h80, 32'h0);
    mem_rdata_i = 32'hDEADBEEF;
    next_cycle();
    next_cycle();
    sample();
    n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", cpu_stall_o); end
    n_vec++; if (mem_en_o !== 1'b0 || mem_be_o !== 4'b0000) begin n_err++; $display("FAIL rst_mem: got en=%b be=%b want 0/0000", mem_en_o, mem_be_o); end
    n_vec++; if (ext_gnt_o !== 1'b0 || align_err_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt_err: got %b/%b want 0/0", ext_gnt_o, align_err_o); end
    n_vec++; if (cpu_rvalid_o !== 1'b0 || ext_rvalid_o !== 1'b0 || cpu_rdata_o !== 32'h0 || ext_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rst_rd: got rv=%b/%b rdata=%h/%h want zeros", cpu_rvalid_o, ext_rvalid_o, cpu_rdata_o, ext_rdata_o); end
    next_cycle();
    reset_i = 1'b0;
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    drive_ext(1'b0, 2'b00, 32'h0, 32'h0);
    sample();
    n_vec++; if (mem_en_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL idle: got en=%b stall=%b want 0/0", mem_en_o, cpu_stall_o); end
  endtask

  task automatic test_cpu_writes();
    next_cycle();
    drive_cpu(1'b1, 2'b11, 32'd81, 32'h000000FF);
    sample();
    n_vec++; if (mem_en_o !== 1'b1 || mem_be_o !== 4'b0010 || mem_addr_o !== 30'd20) begin
      n_err++; $display("FAIL sb: got en=%b be=%b addr=%0d want 1/0010/20", mem_en_o, mem_be_o, mem_addr_o); end
    n_vec++; if (mem_wdata_o !== 32'hFFFFFFFF || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL sb_data: got wd=%h stall=%b want ffffffff/0", mem_wdata_o, cpu_stall_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b10, 32'd82, 32'h0000AAFF);
    sample();
    n_vec++; if (mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hAAFFAAFF || mem_en_o !== 1'b1) begin
      n_err++; $display("FAIL sh_hi: got be=%b wd=%h en=%b want 1100/aaffaaff/1", mem_be_o, mem_wdata_o, mem_en_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b10, 32'd80, 32'h12341234);
    sample();
    n_vec++; if (mem_be_o !== 4'b0011 || mem_wdata_o !== 32'h12341234) begin
      n_err++; $display("FAIL sh_lo: got be=%b wd=%h want 0011/12341234", mem_be_o, mem_wdata_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b11, 32'h103, 32'hCAFE00A5);
    sample();
    n_vec++; if (mem_be_o !== 4'b1000 || mem_wdata_o !== 32'hA5A5A5A5 || mem_addr_o !== 30'h40) begin
      n_err++; $display("FAIL sb_a3: got be=%b wd=%h addr=%h want 1000/a5a5a5a5/40", mem_be_o, mem_wdata_o, mem_addr_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b01, 32'h200, 32'h89ABCDEF);
    sample();
    n_vec++; if (mem_be_o !== 4'b1111 || mem_wdata_o !== 32'h89ABCDEF || mem_addr_o !== 30'h80 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL sw: got be=%b wd=%h addr=%h stall=%b want 1111/89abcdef/80/0", mem_be_o, mem_wdata_o, mem_addr_o, cpu_stall_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b01, 32'd82, 32'h11111111);
    sample();
    n_vec++; if (align_err_o !== 1'b1 || mem_en_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL sw_misalign: got err=%b en=%b stall=%b want 1/0/0", align_err_o, mem_en_o, cpu_stall_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b10, 32'd81, 32'h11111111);
    sample();
    n_vec++; if (align_err_o !== 1'b1 || mem_en_o !== 1'b0) begin
      n_err++; $display("FAIL sh_misalign: got err=%b en=%b want 1/0", align_err_o, mem_en_o); end
    next_cycle();
    drive_cpu(1'b1, 2'b00, 32'd82, 32'h0);
    sample();
    n_vec++; if (align_err_o !== 1'b1 || mem_en_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL lw_misalign: got err=%b en=%b stall=%b want 1/0/0", align_err_o, mem_en_o, cpu_stall_o); end
    next_cycle();
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b0 || align_err_o !== 1'b0) begin
      n_err++; $display("FAIL lw_misalign_norv: got rv=%b err=%b want 0/0", cpu_rvalid_o, align_err_o); end
  endtask

  task automatic test_cpu_read();
    next_cycle();
    drive_cpu(1'b1, 2'b00, 32'd80, 32'h0);
    sample();
    n_vec++; if (cpu_stall_o !== 1'b1 || mem_be_o !== 4'b0000 || mem_addr_o !== 30'd20 || mem_en_o !== 1'b1) begin
      n_err++; $display("FAIL lw_issue: got stall=%b be=%b addr=%0d en=%b want 1/0000/20/1", cpu_stall_o, mem_be_o, mem_addr_o, mem_en_o); end
    next_cycle();
    mem_rdata_i = 32'h0000AAFF;
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'h0000AAFF || cpu_stall_o !== 1'b0 || mem_en_o !== 1'b0) begin
      n_err++; $display("FAIL lw_data: got rv=%b rd=%h stall=%b en=%b want 1/0000aaff/0/0", cpu_rvalid_o, cpu_rdata_o, cpu_stall_o, mem_en_o); end
    next_cycle();
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b0) begin n_err++; $display("FAIL lw_done: got rv=%b want 0", cpu_rvalid_o); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive_cpu(1'b1, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sample();
      n_vec++; if (cpu_stall_o !== 1'b1 || mem_en_o !== 1'b1 || mem_addr_o !== 30'(i)) begin
        n_err++; $display("FAIL b2b_issue%0d: got stall=%b en=%b addr=%0d want 1/1/%0d", i, cpu_stall_o, mem_en_o, mem_addr_o, i); end
      next_cycle();
      mem_rdata_i = 32'h1000 + 32'(i);
      sample();
      n_vec++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'h1000 + 32'(i) || mem_en_o !== 1'b0) begin
        n_err++; $display("FAIL b2b_data%0d: got rv=%b rd=%h en=%b want 1/%h/0", i, cpu_rvalid_o, cpu_rdata_o, mem_en_o, 32'h1000 + 32'(i)); end
      next_cycle();
      drive_cpu(1'b1, 2'b00, 32'(4 * (i + 1)), 32'h0);
    end
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_starvation();
    next_cycle();
    drive_ext(1'b1, 2'b01, 32'h300, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) begin
      drive_cpu(1'b1, 2'b01, 32'h200 + 32'(4 * i), 32'h0);
      sample();
      n_vec++; if (ext_gnt_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_addr_o !== 30'h80 + 30'(i)) begin
        n_err++; $display("FAIL starve_cpu%0d: got gnt=%b stall=%b addr=%h want 0/0/%h", i, ext_gnt_o, cpu_stall_o, mem_addr_o, 30'h80 + 30'(i)); end
      next_cycle();
    end
    drive_cpu(1'b1, 2'b01, 32'h210, 32'h0);
    sample();
    n_vec++; if (ext_gnt_o !== 1'b1 || cpu_stall_o !== 1'b1 || mem_addr_o !== 30'hC0 || mem_wdata_o !== 32'h5A5A5A5A) begin
      n_err++; $display("FAIL starve_ext: got gnt=%b stall=%b addr=%h wd=%h want 1/1/c0/5a5a5a5a", ext_gnt_o, cpu_stall_o, mem_addr_o, mem_wdata_o); end
    next_cycle();
    drive_ext(1'b1, 2'b01, 32'h304, 32'h0);
    sample();
    n_vec++; if (ext_gnt_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_addr_o !== 30'h84) begin
      n_err++; $display("FAIL starve_clear: got gnt=%b stall=%b addr=%h want 0/0/84", ext_gnt_o, cpu_stall_o, mem_addr_o); end
    next_cycle();
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    drive_ext(1'b1, 2'b10, 32'h305, 32'h0);
    sample();
    n_vec++; if (ext_gnt_o !== 1'b1 || align_err_o !== 1'b1 || mem_en_o !== 1'b0) begin
      n_err++; $display("FAIL ext_misalign: got gnt=%b err=%b en=%b want 1/1/0", ext_gnt_o, align_err_o, mem_en_o); end
    next_cycle();
    drive_ext(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_ext_read();
    next_cycle();
    drive_ext(1'b1, 2'b00, 32'h100, 32'h0);
    sample();
    n_vec++; if (ext_gnt_o !== 1'b1 || mem_en_o !== 1'b1 || mem_be_o !== 4'b0000 || mem_addr_o !== 30'h40 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL ext_issue: got gnt=%b en=%b be=%b addr=%h stall=%b want 1/1/0000/40/0", ext_gnt_o, mem_en_o, mem_be_o, mem_addr_o, cpu_stall_o); end
    next_cycle();
    drive_ext(1'b0, 2'b00, 32'h0, 32'h0);
    drive_cpu(1'b1, 2'b01, 32'h10, 32'h12345678);
    mem_rdata_i = 32'hFEEDF00D;
    sample();
    n_vec++; if (ext_rvalid_o !== 1'b1 || ext_rdata_o !== 32'hFEEDF00D || cpu_stall_o !== 1'b1 || mem_en_o !== 1'b0 || cpu_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL ext_data: got rv=%b rd=%h stall=%b en=%b crv=%b want 1/feedf00d/1/0/0", ext_rvalid_o, ext_rdata_o, cpu_stall_o, mem_en_o, cpu_rvalid_o); end
    next_cycle();
    sample();
    n_vec++; if (mem_en_o !== 1'b1 || mem_be_o !== 4'b1111 || mem_addr_o !== 30'h4 || cpu_stall_o !== 1'b0 || ext_rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL ext_cpu_after: got en=%b be=%b addr=%h stall=%b erv=%b want 1/1111/4/0/0", mem_en_o, mem_be_o, mem_addr_o, cpu_stall_o, ext_rvalid_o); end
    next_cycle();
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_in_read();
    next_cycle();
    drive_cpu(1'b1, 2'b00, 32'h8, 32'h0);
    sample();
    n_vec++; if (cpu_stall_o !== 1'b1 || mem_en_o !== 1'b1) begin
      n_err++; $display("FAIL rr_issue: got stall=%b en=%b want 1/1", cpu_stall_o, mem_en_o); end
    next_cycle();
    reset_i = 1'b1;
    mem_rdata_i = 32'h77777777;
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b0 || cpu_rdata_o !== 32'h0 || cpu_stall_o !== 1'b0 || mem_en_o !== 1'b0) begin
      n_err++; $display("FAIL rr_reset: got rv=%b rd=%h stall=%b en=%b want 0/0/0/0", cpu_rvalid_o, cpu_rdata_o, cpu_stall_o, mem_en_o); end
    next_cycle();
    reset_i = 1'b0;
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b0 || mem_en_o !== 1'b1 || mem_addr_o !== 30'h2 || cpu_stall_o !== 1'b1) begin
      n_err++; $display("FAIL rr_reissue: got rv=%b en=%b addr=%h stall=%b want 0/1/2/1", cpu_rvalid_o, mem_en_o, mem_addr_o, cpu_stall_o); end
    next_cycle();
    mem_rdata_i = 32'h24682468;
    sample();
    n_vec++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'h24682468) begin
      n_err++; $display("FAIL rr_data: got rv=%b rd=%h want 1/24682468", cpu_rvalid_o, cpu_rdata_o); end
    next_cycle();
    drive_cpu(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_cpu_writes();
    test_cpu_read();
    test_back_to_back();
    test_starvation();
    test_ext_read();
    test_reset_in_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
